// File: rtl/multiword_adder_pkg.sv
// -----------------------------------------------------------------------------
// multiword_adder_pkg
//   Shared types and helpers for the multi-word add/subtract sequencer.
//   - state_t       : sequencer states (IDLE, RUN, DONE)
//   - idx_width()   : width of the word index for a given word count
// -----------------------------------------------------------------------------
package multiword_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word index width. Clamped to at least one bit so a degenerate word count
  // still yields a legal vector.
  function automatic int idx_width(input int num_words);
    return (num_words < 2) ? 1 : $clog2(num_words);
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder
//   Purely combinational bit_width-wide ripple carry adder.
//   Ports:
//     a, b  : addends (bit_width)
//     cin   : carry in
//     s     : sum (bit_width)
//     cout  : carry out of the most significant bit
// -----------------------------------------------------------------------------
module ripple_carry_adder #(
  parameter int bit_width = 8
) (
  input  logic [bit_width-1:0] a,
  input  logic [bit_width-1:0] b,
  input  logic                 cin,
  output logic [bit_width-1:0] s,
  output logic                 cout
);

  // The carry is a single variable threaded through the loop, so the chain
  // is expressed in order without a feedback vector.
  always_comb begin
    logic c;
    // NOTE: every output of a combinational block gets a value before any
    // conditional or loop logic; otherwise a path that skips the assignment
    // infers a latch.
    s    = '0;
    c    = cin;
    for (int i = 0; i < bit_width; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/multiword_adder_ctrl.sv
// -----------------------------------------------------------------------------
// multiword_adder_ctrl
//   Wide (num_words x bit_width) add/subtract using one shared bit_width adder,
//   one word per cycle, least-significant word first. Carry is held in a
//   register between words.
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//     a, b                 : operands (bit_width*num_words)
//     cin                  : carry in for add, ignored for subtract
//     sub                  : 1 = a - b
//     out_valid / out_ready: result handshake (out_valid high only in DONE)
//     sum                  : registered result (bit_width*num_words)
//     cout                 : final carry; for subtract 1 = no borrow
// -----------------------------------------------------------------------------
module multiword_adder_ctrl
  import multiword_adder_pkg::*;
#(
  parameter int bit_width = 8,
  parameter int num_words = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [bit_width*num_words-1:0] a,
  input  logic [bit_width*num_words-1:0] b,
  input  logic                           cin,
  input  logic                           sub,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [bit_width*num_words-1:0] sum,
  output logic                           cout
);

  localparam int total_width = bit_width * num_words;
  localparam int iw          = idx_width(num_words);

  state_t                 state_q, state_d;
  logic [total_width-1:0] a_q, b_q, sum_q;
  logic                   carry_q;
  logic [iw-1:0]          idx_q;
  logic                   last_word;
  logic                   accept;

  logic [bit_width-1:0]   add_a, add_b, add_s;
  logic                   add_cout;

  assign last_word = (idx_q == iw'(num_words - 1));
  assign accept    = (state_q == IDLE) && in_valid;

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  // The carry register holds the final word's carry once in DONE.
  assign cout      = carry_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared word adder
  // ---------------------------------------------------------------------------
  assign add_a = a_q[idx_q*bit_width +: bit_width];
  assign add_b = b_q[idx_q*bit_width +: bit_width];

  ripple_carry_adder #(
    .bit_width(bit_width)
  ) u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (carry_q),
    .s   (add_s),
    .cout(add_cout)
  );

  // ---------------------------------------------------------------------------
  // Control and result registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            sum_q   <= '0;
          end
        end
        RUN: begin
          sum_q[idx_q*bit_width +: bit_width] <= add_s;
          carry_q <= add_cout;
          if (!last_word) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Captured operands. Subtraction is a + ~b + 1, so b is inverted here and
  // the +1 enters through the carry register.
  // NOTE: these data registers carry no reset; they are always loaded on
  // accept before they are read, so resetting them only costs routing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end
  end

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multiword_adder_ctrl
//   Self-checking bench for multiword_adder_ctrl (bit_width=8, num_words=4).
//   Directed vector table, hand-written corner sequences (backpressure hold,
//   mid-operation reset) and randomized operations against a 32-bit model.
// -----------------------------------------------------------------------------
module tb_multiword_adder_ctrl;

  localparam int bw = 8;
  localparam int nw = 4;
  localparam int tw = bw * nw;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [tw-1:0] a, b;
  logic          cin, sub;
  logic          out_valid;
  logic          out_ready;
  logic [tw-1:0] sum;
  logic          cout;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int handshakes = 0;

  multiword_adder_ctrl #(
    .bit_width(bw),
    .num_words(nw)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)   accepts++;
      if (out_valid && out_ready) handshakes++;
    end
  end

  typedef struct {
    logic [tw-1:0] a;
    logic [tw-1:0] b;
    logic          cin;
    logic          sub;
    logic [tw-1:0] exp_sum;
    logic          exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic. Subtraction carry means "no borrow".
  function automatic logic [tw:0] model(input logic [tw-1:0] x, input logic [tw-1:0] y,
                                        input logic c, input logic s);
    if (s) return {(x >= y) ? 1'b1 : 1'b0, x - y};
    return {1'b0, x} + {1'b0, y} + {{tw{1'b0}}, c};
  endfunction

  // Present an operand set, wait for acceptance and then for out_valid.
  // lat counts clock edges from the accept edge (inclusive) until out_valid.
  task automatic start_op(input logic [tw-1:0] xa, input logic [tw-1:0] xb,
                          input logic xc, input logic xs, input string tag,
                          output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_in_ready_wait"}, 64'(in_ready), 64'd1);
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    // Operands need only be stable in the accept cycle; scramble them.
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_out_valid_wait"}, 64'(out_valid), 64'd1);
  endtask

  // Complete the result handshake and check the return to IDLE.
  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    vec_t          vecs[6];
    int            lat;
    int            acc0, hs0;
    logic [tw-1:0] ra, rb;
    logic          rc, rs;
    logic [tw:0]   exp;
    bit            seen;
    string         tag;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0};
    vecs[2] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum",       64'(sum),       64'd0);
    check("reset_cout",      64'(cout),      64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("vec%0d", i);
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, tag, lat);
      check({tag, "_latency"}, 64'(lat), 64'(nw + 1));
      check({tag, "_sum"},  64'(sum),  64'(vecs[i].exp_sum));
      check({tag, "_cout"}, 64'(cout), 64'(vecs[i].exp_cout));
      finish_op(tag);
    end

    // Backpressure: hold DONE for 10 cycles while in_valid pulses
    start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, "hold", lat);
    acc0 = accepts;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 3 == 0);
      a = $urandom; b = $urandom;
      @(negedge clk);
      check($sformatf("hold%0d_sum", i), 64'(sum), 64'h0001_0000);
      check($sformatf("hold%0d_cout", i), 64'(cout), 64'd0);
      check($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'd0);
      check($sformatf("hold%0d_out_valid", i), 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    check("hold_no_accept", 64'(accepts - acc0), 64'd0);
    finish_op("hold");

    // Reset while RUN is on word index 2
    a = 32'hDEAD_BEEF; b = 32'h0123_4567; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);           // RUN, idx 0
    in_valid = 1'b0;
    repeat (2) @(negedge clk); // RUN, idx 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run_in_ready",  64'(in_ready),  64'd1);
    check("rst_run_out_valid", 64'(out_valid), 64'd0);
    check("rst_run_sum",       64'(sum),       64'd0);
    check("rst_run_cout",      64'(cout),      64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("rst_run_no_result", 64'(seen), 64'd0);
    start_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, "post_rst", lat);
    check("post_rst_sum",  64'(sum),  64'h0000_0002);
    check("post_rst_cout", 64'(cout), 64'd0);
    finish_op("post_rst");

    // Randomized operations with random consumer stalls
    acc0 = accepts; hs0 = handshakes;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;  // exercise the equal-operands borrow edge
      exp = model(ra, rb, rc, rs);
      tag = $sformatf("rnd%0d", i);
      start_op(ra, rb, rc, rs, tag, lat);
      check({tag, "_latency"}, 64'(lat), 64'(nw + 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check({tag, "_sum"},  64'(sum),  64'(exp[tw-1:0]));
      check({tag, "_cout"}, 64'(cout), 64'(exp[tw]));
      finish_op(tag);
    end
    check("rnd_accept_count", 64'(accepts - acc0), 64'd40);
    check("rnd_handshake_count", 64'(handshakes - hs0), 64'(accepts - acc0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
